// File: rtl/dsi_pkg.sv
// rtl/dsi_pkg.sv - shared state encoding and timing constants for the DSI HS burst sequencer
package dsi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LPX,
      ST_PREP,
      ST_ZERO,
      ST_SYNC,
      ST_DATA,
      ST_TRAIL,
      ST_EXIT
   } dsi_state_t;

   localparam logic [7:0] SYNC_BYTE   = 8'hB8;

   localparam logic [7:0] DEF_T_LPX   = 8'd4;
   localparam logic [7:0] DEF_T_PREP  = 8'd3;
   localparam logic [7:0] DEF_T_ZERO  = 8'd10;
   localparam logic [7:0] DEF_T_TRAIL = 8'd5;
   localparam logic [7:0] DEF_T_EXIT  = 8'd8;

   // A zero-length phase would never be visible on the lines, so it is stretched to one cycle.
   function automatic logic [7:0] dur_eff(input logic [7:0] t);
      return (t == 8'd0) ? 8'd1 : t;
   endfunction

endpackage

// File: rtl/dsi_hs_seq_if.sv
// rtl/dsi_hs_seq_if.sv - payload byte stream between the packet source and the HS sequencer
interface dsi_hs_seq_if;
   logic       I_hs_valid;
   logic [7:0] I_hs_data;
   logic       I_hs_last;
   logic       O_hs_rdy;

   modport master (
      output I_hs_valid,
      output I_hs_data,
      output I_hs_last,
      input  O_hs_rdy
   );

   modport slave (
      input  I_hs_valid,
      input  I_hs_data,
      input  I_hs_last,
      output O_hs_rdy
   );
endinterface

// File: rtl/dsi_dur_cnt.sv
// rtl/dsi_dur_cnt.sv - loadable 8-bit down-counter that parks at zero and flags it
module dsi_dur_cnt (
   input  logic       I_clk,
   input  logic       I_rst,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       zero
);

   logic [7:0] cnt;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         cnt <= 8'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != 8'd0) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign zero = (cnt == 8'd0);

endmodule

// File: rtl/dsi_hs_seq.sv
// rtl/dsi_hs_seq.sv - DSI lane LP->HS entry, payload burst and HS->LP exit sequencer
module dsi_hs_seq
   import dsi_pkg::*;
#(
   parameter logic [7:0] T_LPX   = DEF_T_LPX,
   parameter logic [7:0] T_PREP  = DEF_T_PREP,
   parameter logic [7:0] T_ZERO  = DEF_T_ZERO,
   parameter logic [7:0] T_TRAIL = DEF_T_TRAIL,
   parameter logic [7:0] T_EXIT  = DEF_T_EXIT
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_serdes_ready,
   input  logic        I_hs_req,
   dsi_hs_seq_if.slave hs,
   output logic [7:0]  O_hs_data,
   output logic        O_hs_en,
   output logic        O_lp_p,
   output logic        O_lp_n,
   output logic        O_busy,
   output logic        O_abort,
   output logic        O_underrun
);

   localparam logic [7:0] LPX_N   = dur_eff(T_LPX);
   localparam logic [7:0] PREP_N  = dur_eff(T_PREP);
   localparam logic [7:0] ZERO_N  = dur_eff(T_ZERO);
   localparam logic [7:0] TRAIL_N = dur_eff(T_TRAIL);
   localparam logic [7:0] EXIT_N  = dur_eff(T_EXIT);

   dsi_state_t state_q;
   dsi_state_t state_nxt;

   logic       hs_rdy_q;
   logic       got_byte_q;
   logic       last_bit_q;

   logic       cnt_load;
   logic [7:0] cnt_val;
   logic       cnt_zero;

   logic       xfer;
   logic       serdes_lost;

   logic       lp_p_nxt;
   logic       lp_n_nxt;
   logic       hs_en_nxt;
   logic       hs_rdy_nxt;
   logic [7:0] hs_data_nxt;
   logic       abort_nxt;
   logic       underrun_nxt;

   assign xfer        = (state_q == ST_DATA) && hs_rdy_q && hs.I_hs_valid;
   assign serdes_lost = !I_serdes_ready && (state_q != ST_IDLE) && (state_q != ST_EXIT);
   assign hs.O_hs_rdy = hs_rdy_q;

   dsi_dur_cnt u_dur_cnt (
      .I_clk    (I_clk),
      .I_rst    (I_rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   // Every output is registered from its *_nxt value so the pins change together with the state.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q    <= ST_IDLE;
         O_lp_p     <= 1'b1;
         O_lp_n     <= 1'b1;
         O_hs_en    <= 1'b0;
         hs_rdy_q   <= 1'b0;
         O_hs_data  <= 8'h00;
         O_busy     <= 1'b0;
         O_abort    <= 1'b0;
         O_underrun <= 1'b0;
         got_byte_q <= 1'b0;
         last_bit_q <= 1'b1;
      end else begin
         state_q    <= state_nxt;
         O_lp_p     <= lp_p_nxt;
         O_lp_n     <= lp_n_nxt;
         O_hs_en    <= hs_en_nxt;
         hs_rdy_q   <= hs_rdy_nxt;
         O_hs_data  <= hs_data_nxt;
         O_busy     <= (state_nxt != ST_IDLE);
         O_abort    <= abort_nxt;
         O_underrun <= underrun_nxt;
         if (state_nxt == ST_SYNC) begin
            got_byte_q <= 1'b0;
            last_bit_q <= SYNC_BYTE[7];
         end else if (xfer) begin
            got_byte_q <= 1'b1;
            last_bit_q <= hs.I_hs_data[7];
         end
      end
   end

   always_comb begin
      state_nxt = state_q;
      if (serdes_lost) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (I_hs_req && I_serdes_ready) state_nxt = ST_LPX;
            ST_LPX:   if (cnt_zero) state_nxt = ST_PREP;
            ST_PREP:  if (cnt_zero) state_nxt = ST_ZERO;
            ST_ZERO:  if (cnt_zero) state_nxt = ST_SYNC;
            ST_SYNC:  state_nxt = ST_DATA;
            ST_DATA: begin
               if (xfer && hs.I_hs_last) begin
                  state_nxt = ST_TRAIL;
               end else if (!hs.I_hs_valid && got_byte_q) begin
                  state_nxt = ST_TRAIL;
               end
            end
            ST_TRAIL: if (cnt_zero) state_nxt = ST_EXIT;
            ST_EXIT:  if (cnt_zero) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      lp_p_nxt     = 1'b1;
      lp_n_nxt     = 1'b1;
      hs_en_nxt    = 1'b0;
      hs_rdy_nxt   = 1'b0;
      hs_data_nxt  = 8'h00;
      abort_nxt    = serdes_lost;
      underrun_nxt = 1'b0;
      cnt_load     = (state_nxt != state_q);
      cnt_val      = 8'd0;
      case (state_nxt)
         ST_LPX: begin
            lp_p_nxt = 1'b0;
            cnt_val  = LPX_N - 8'd1;
         end
         ST_PREP: begin
            lp_p_nxt = 1'b0;
            lp_n_nxt = 1'b0;
            cnt_val  = PREP_N - 8'd1;
         end
         ST_ZERO: begin
            lp_p_nxt  = 1'b0;
            lp_n_nxt  = 1'b0;
            hs_en_nxt = 1'b1;
            cnt_val   = ZERO_N - 8'd1;
         end
         ST_SYNC: begin
            lp_p_nxt    = 1'b0;
            lp_n_nxt    = 1'b0;
            hs_en_nxt   = 1'b1;
            hs_data_nxt = SYNC_BYTE;
         end
         ST_DATA: begin
            lp_p_nxt    = 1'b0;
            lp_n_nxt    = 1'b0;
            hs_en_nxt   = 1'b1;
            hs_rdy_nxt  = 1'b1;
            hs_data_nxt = xfer ? hs.I_hs_data : O_hs_data;
         end
         ST_TRAIL: begin
            lp_p_nxt  = 1'b0;
            lp_n_nxt  = 1'b0;
            hs_en_nxt = 1'b1;
            // The final byte still needs its own cycle on the wire, so the trail is loaded one longer.
            if (xfer) begin
               hs_data_nxt = hs.I_hs_data;
               cnt_val     = TRAIL_N;
            end else begin
               hs_data_nxt = {8{~last_bit_q}};
               cnt_val     = TRAIL_N - 8'd1;
            end
            underrun_nxt = (state_q == ST_DATA) && !xfer;
         end
         ST_EXIT: begin
            cnt_val = EXIT_N - 8'd1;
         end
         default: begin
            cnt_val = 8'd0;
         end
      endcase
   end

endmodule

// File: doc/dsi_hs_seq.md
DSI_HS_SEQ -- requirements
Module: dsi_hs_seq

Interface
REQ-001 Parameter T_LPX, default 4, LP-01 duration in I_clk cycles (8-bit).
REQ-002 Parameter T_PREP, default 3, LP-00 (HS-prepare) duration in cycles.
REQ-003 Parameter T_ZERO, default 10, HS-zero duration in cycles.
REQ-004 Parameter T_TRAIL, default 5, HS-trail duration in cycles.
REQ-005 Parameter T_EXIT, default 8, LP-11 hold after trail before next burst.
REQ-006 I_clk  in  1  single clock for all logic.
REQ-007 I_rst  in  1  reset, synchronous, active-high.
REQ-008 I_serdes_ready  in  1  serdes out of reset and PLL locked.
REQ-009 I_hs_req  in  1  level request for one HS burst.
REQ-010 I_hs_valid  in  1  payload byte valid.
REQ-011 I_hs_data  in  8  payload byte, LSB transmitted first.
REQ-012 I_hs_last  in  1  qualifies final byte of burst.
REQ-013 O_hs_rdy  out  1  payload accept; byte transfers when I_hs_valid & O_hs_rdy.
REQ-014 O_hs_data  out  8  byte to serdes.
REQ-015 O_hs_en  out  1  HS driver enable.
REQ-016 O_lp_p, O_lp_n  out  1 each  LP line levels.
REQ-017 O_busy  out  1  high in any state except IDLE.
REQ-018 O_abort  out  1  one-cycle pulse, burst aborted by serdes loss.
REQ-019 O_underrun  out  1  one-cycle pulse, valid dropped mid-burst.

Function
REQ-020 All outputs SHALL be registered and reflect the state being entered on that edge.
REQ-021 States SHALL be IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT.
REQ-022 IDLE: LP=11, O_hs_en=0, O_hs_data=0x00; go to LPX when I_hs_req & I_serdes_ready.
REQ-023 LPX: LP=01 for exactly T_LPX cycles, then PREP.
REQ-024 PREP: LP=00, O_hs_en=0 for exactly T_PREP cycles, then ZERO.
REQ-025 ZERO: LP=00, O_hs_en=1, O_hs_data=0x00 for exactly T_ZERO cycles, then SYNC.
REQ-026 SYNC: one cycle, O_hs_data=0xB8, O_hs_en=1; then DATA.
REQ-027 DATA: O_hs_rdy=1; accepted byte appears on O_hs_data the following cycle (latency 1).
REQ-028 DATA: transfer with I_hs_last=1 SHALL deassert O_hs_rdy next cycle and enter TRAIL.
REQ-029 DATA: I_hs_valid low in DATA after first transfer SHALL pulse O_underrun and enter TRAIL; valid low before first transfer is a wait, not underrun.
REQ-030 TRAIL: O_hs_data all bits = inverse of bit7 of last transmitted byte (0xB8 if none), for exactly T_TRAIL cycles, then EXIT.
REQ-031 EXIT: LP=11, O_hs_en=0 for exactly T_EXIT cycles, then IDLE; I_hs_req ignored until IDLE.
REQ-032 I_serdes_ready low in any state except IDLE/EXIT SHALL enter IDLE next edge, pulse O_abort, drop O_hs_en/O_hs_rdy.
REQ-033 Timing parameter value 0 SHALL behave as 1.
REQ-034 Duration counter SHALL be 8-bit, loaded with T-1 on state entry, advance on zero; no wrap.

Reset
REQ-035 I_rst high at a clock edge SHALL force IDLE, LP=11, O_hs_en=0, O_hs_rdy=0, O_hs_data=0x00, O_busy=0, O_abort=0, O_underrun=0, counter=0, last-bit latch=1.
REQ-036 Reset mid-burst SHALL take effect on the next edge with no trail.

Structure
REQ-037 Package dsi_pkg SHALL hold the state enumeration, sync byte 0xB8, and default timing constants.
REQ-038 One sub-module dsi_dur_cnt (loadable 8-bit down-counter with zero flag) SHALL be used.

Verification
REQ-039 Defaults, req with ready, 3-byte burst 0x11,0x22,0x33(last) -> LP01 4 cyc, LP00 3 cyc, 0x00 x10, 0xB8, 0x11,0x22,0x33, trail 0xFF x5, LP11 8 cyc.
REQ-040 Last byte 0x80 -> trail bytes 0x00 x5.
REQ-041 Valid drops after second byte -> O_underrun 1 cycle, TRAIL entered next edge.
REQ-042 I_serdes_ready low during ZERO -> next cycle IDLE, O_abort 1 cycle, O_hs_en=0.
REQ-043 I_rst high during DATA -> next cycle all outputs at reset values; req with ready low -> stays IDLE.
